miriscv_lsu: RTL and testbench

MIRISCV_LSU -- requirements
Module: miriscv_lsu

---
 rtl/miriscv_lsu.sv | 142 ++++++++++++++
 tb/tb_miriscv_lsu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
// Load/store unit: one legal access takes two cycles (issue with stall, then a release cycle where load data returns).
// Illegal accesses are rejected in the issue cycle with a one-cycle error pulse and no memory request.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [31:0] lsu_data_q, lsu_data_d;

  logic        illegal;
  logic        issue;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  always_comb begin
    illegal = 1'b0;
    case (lsu_size_i)
      SZ_B:    illegal = 1'b0;
      SZ_BU:   illegal = lsu_we_i;
      SZ_H:    illegal = lsu_addr_i[0];
      SZ_HU:   illegal = lsu_we_i | lsu_addr_i[0];
      SZ_W:    illegal = (lsu_addr_i[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  assign issue = (state_q == ST_IDLE) && lsu_req_i && !illegal;

  // Lane select uses the offset latched at issue, since the core may move on in the WAIT cycle.
  assign rd_byte = data_rdata_i[{off_q, 3'b000} +: 8];
  assign rd_half = data_rdata_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = data_rdata_i;
    case (size_q)
      SZ_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
      SZ_BU:   load_val = {24'h0, rd_byte};
      SZ_H:    load_val = {{16{rd_half[15]}}, rd_half};
      SZ_HU:   load_val = {16'h0, rd_half};
      default: load_val = data_rdata_i;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    size_d          = size_q;
    we_d            = we_q;
    lsu_data_d      = lsu_data_q;
    lsu_data_o      = lsu_data_q;
    lsu_stall_req_o = 1'b0;
    lsu_err_o       = 1'b0;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_be_o       = 4'b0000;
    data_addr_o     = 32'h0;
    data_wdata_o    = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i && illegal) begin
          lsu_err_o = 1'b1;
        end else if (issue) begin
          data_req_o      = 1'b1;
          lsu_stall_req_o = 1'b1;
          data_we_o       = lsu_we_i;
          data_addr_o     = {lsu_addr_i[31:2], 2'b00};
          case (lsu_size_i[1:0])
            2'b00: begin
              data_be_o    = 4'b0001 << lsu_addr_i[1:0];
              data_wdata_o = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
              data_be_o    = 4'b0011 << lsu_addr_i[1:0];
              data_wdata_o = {2{lsu_data_i[15:0]}};
            end
            default: begin
              data_be_o    = 4'b1111;
              data_wdata_o = lsu_data_i;
            end
          endcase
          off_d   = lsu_addr_i[1:0];
          size_d  = lsu_size_i;
          we_d    = lsu_we_i;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!we_q) begin
          lsu_data_o = load_val;
          lsu_data_d = load_val;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      off_q      <= 2'b00;
      size_q     <= 3'b000;
      we_q       <= 1'b0;
      lsu_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      we_q       <= we_d;
      lsu_data_q <= lsu_data_d;
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu with a one-cycle-latency read memory model.
// Inputs change on the falling edge; outputs are sampled 1ns later, before the next rising edge.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [31:0] lsu_data;
  logic        lsu_stall, lsu_err;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic [31:0] data_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  miriscv_lsu dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_data_i      (lsu_wdata),
    .lsu_data_o      (lsu_data),
    .lsu_stall_req_o (lsu_stall),
    .lsu_err_o       (lsu_err),
    .data_req_o      (data_req),
    .data_we_o       (data_we),
    .data_be_o       (data_be),
    .data_addr_o     (data_addr),
    .data_wdata_o    (data_wdata),
    .data_rdata_i    (data_rdata)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h8000_80FF;
      32'h14:  return 32'h1234_5678;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (data_req && !data_we) data_rdata <= mem_rd(data_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    lsu_req   = req;
    lsu_we    = we;
    lsu_size  = sz;
    lsu_addr  = addr;
    lsu_wdata = wd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // Full two-cycle load: checks issue-cycle outputs and the returned value.
  task automatic do_load(input string tag, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, addr, 32'h0);
    check({tag, "_req"}, {31'h0, data_req}, 32'd1);
    check({tag, "_stall"}, {31'h0, lsu_stall}, 32'd1);
    check({tag, "_be"}, {28'h0, data_be}, {28'h0, be});
    check({tag, "_addr"}, data_addr, {addr[31:2], 2'b00});
    idle();
    check({tag, "_wstall"}, {31'h0, lsu_stall}, 32'd0);
    check({tag, "_data"}, lsu_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'b000; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", {31'h0, lsu_stall}, 32'd0);
    check("rst_err",   {31'h0, lsu_err},   32'd0);
    check("rst_req",   {31'h0, data_req},  32'd0);
    check("rst_be",    {28'h0, data_be},   32'd0);
    check("rst_data",  lsu_data,           32'h0);

    do_load("lb10",  3'b000, 32'h10, 4'b0001, 32'hFFFF_FFFF);
    idle();
    check("lb10_hold", lsu_data, 32'hFFFF_FFFF);
    do_load("lhu12", 3'b101, 32'h12, 4'b1100, 32'h0000_8000);
    do_load("lh12",  3'b001, 32'h12, 4'b1100, 32'hFFFF_8000);
    do_load("lbu13", 3'b100, 32'h13, 4'b1000, 32'h0000_0080);
    do_load("lb11",  3'b000, 32'h11, 4'b0010, 32'hFFFF_FF80);
    do_load("lw10",  3'b010, 32'h10, 4'b1111, 32'h8000_80FF);

    // Stores: lane replication and no update of load result
    drive(1'b1, 1'b1, 3'b000, 32'h13, 32'h0000_00AB);
    check("sb_we",    {31'h0, data_we}, 32'd1);
    check("sb_be",    {28'h0, data_be}, 32'h8);
    check("sb_wdata", data_wdata,       32'hABAB_ABAB);
    check("sb_addr",  data_addr,        32'h10);
    check("sb_stall", {31'h0, lsu_stall}, 32'd1);
    idle();
    check("sb_nodata", lsu_data, 32'h8000_80FF);
    drive(1'b1, 1'b1, 3'b001, 32'h16, 32'h5555_1234);
    check("sh_be",    {28'h0, data_be}, 32'hC);
    check("sh_wdata", data_wdata,       32'h1234_1234);
    idle();
    drive(1'b1, 1'b1, 3'b010, 32'h14, 32'hCAFE_F00D);
    check("sw_wdata", data_wdata,       32'hCAFE_F00D);
    check("sw_be",    {28'h0, data_be}, 32'hF);
    idle();
    check("sw_nodata", lsu_data, 32'h8000_80FF);

    // Illegal accesses
    drive(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    check("lw22_err",   {31'h0, lsu_err},   32'd1);
    check("lw22_req",   {31'h0, data_req},  32'd0);
    check("lw22_stall", {31'h0, lsu_stall}, 32'd0);
    idle();
    check("lw22_errclr", {31'h0, lsu_err}, 32'd0);
    check("lw22_data",   lsu_data,         32'h8000_80FF);
    drive(1'b1, 1'b1, 3'b001, 32'h21, 32'h0);
    check("sh21_err", {31'h0, lsu_err}, 32'd1);
    drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    check("sz011_err", {31'h0, lsu_err}, 32'd1);
    drive(1'b1, 1'b1, 3'b100, 32'h10, 32'h0);
    check("sbu_err", {31'h0, lsu_err}, 32'd1);
    drive(1'b1, 1'b0, 3'b111, 32'h10, 32'h0);
    check("sz111_req", {31'h0, data_req}, 32'd0);
    idle();

    // Back-to-back loads: second request presented during the WAIT cycle
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("b2b_c1_req", {31'h0, data_req}, 32'd1);
    check("b2b_c1_stall", {31'h0, lsu_stall}, 32'd1);
    drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    check("b2b_c2_req",   {31'h0, data_req},  32'd0);
    check("b2b_c2_stall", {31'h0, lsu_stall}, 32'd0);
    check("b2b_c2_data",  lsu_data,           32'h8000_80FF);
    drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    check("b2b_c3_req",   {31'h0, data_req},  32'd1);
    check("b2b_c3_stall", {31'h0, lsu_stall}, 32'd1);
    check("b2b_c3_addr",  data_addr,          32'h14);
    idle();
    check("b2b_c4_stall", {31'h0, lsu_stall}, 32'd0);
    check("b2b_c4_data",  lsu_data,           32'h1234_5678);

    // Reset during WAIT discards the response
    do_load("prelb", 3'b000, 32'h10, 4'b0001, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    check("rw_c1_req", {31'h0, data_req}, 32'd1);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rw_data",  lsu_data,           32'h0);
    check("rw_stall", {31'h0, lsu_stall}, 32'd0);
    check("rw_req",   {31'h0, data_req},  32'd0);
    idle();
    check("rw_hold", lsu_data, 32'h0);
    do_load("post_rst", 3'b100, 32'h10, 4'b0001, 32'h0000_00FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
